// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts PATTERN out MSB-first, R copies separated by G zero bits.
// Define SEQ_TX_PARITY_EN to append an even-parity bit after every copy.
module seq_pattern_tx #(
   parameter int               PAT_W   = 4,
   parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
   parameter int               CNT_W   = 8,
   parameter int               GAP_W   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] repeat_cnt,
   input  logic [GAP_W-1:0] gap_len,
   output logic             dout,
   output logic             dvalid,
   output logic             busy,
   output logic             done
);

   localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_SEND = 3'd1;
   localparam logic [2:0] ST_GAP  = 3'd2;
   localparam logic [2:0] ST_DONE = 3'd3;
`ifdef SEQ_TX_PARITY_EN
   localparam logic [2:0] ST_PAR  = 3'd4;
   localparam logic       PAR_BIT = ^PATTERN;
`endif

   logic [2:0]       state_reg, state_next;
   logic [IDX_W-1:0] idx_reg, idx_next;
   logic [CNT_W-1:0] copy_reg, copy_next;
   logic [GAP_W-1:0] gap_reg, gap_next;
   logic [CNT_W-1:0] r_reg, r_next;
   logic [GAP_W-1:0] g_reg, g_next;
   logic             dout_reg, dout_next;
   logic             dvalid_reg, dvalid_next;
   logic             busy_reg, busy_next;
   logic             done_reg, done_next;

   // Where the transfer goes once a copy (and its parity bit, if any) is complete.
   logic [2:0]       adv_state;
   logic [IDX_W-1:0] adv_idx;
   logic [CNT_W-1:0] adv_copy;
   logic [GAP_W-1:0] adv_gap;

   always_comb begin
      adv_state = ST_SEND;
      adv_idx   = IDX_TOP;
      adv_copy  = copy_reg + CNT_W'(1);
      adv_gap   = gap_reg;
      if (copy_reg == r_reg) begin
         adv_state = ST_DONE;
         adv_idx   = idx_reg;
         adv_copy  = copy_reg;
      end else if (g_reg != '0) begin
         adv_state = ST_GAP;
         adv_idx   = idx_reg;
         adv_copy  = copy_reg;
         adv_gap   = g_reg;
      end
   end

   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      copy_next  = copy_reg;
      gap_next   = gap_reg;
      r_next     = r_reg;
      g_next     = g_reg;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               r_next = repeat_cnt;
               g_next = gap_len;
               if (repeat_cnt == '0) begin
                  state_next = ST_DONE;
               end else begin
                  state_next = ST_SEND;
                  idx_next   = IDX_TOP;
                  copy_next  = CNT_W'(1);
               end
            end
         end
         ST_SEND: begin
            if (idx_reg != '0) begin
               idx_next = idx_reg - IDX_W'(1);
            end else begin
`ifdef SEQ_TX_PARITY_EN
               state_next = ST_PAR;
`else
               state_next = adv_state;
               idx_next   = adv_idx;
               copy_next  = adv_copy;
               gap_next   = adv_gap;
`endif
            end
         end
`ifdef SEQ_TX_PARITY_EN
         ST_PAR: begin
            state_next = adv_state;
            idx_next   = adv_idx;
            copy_next  = adv_copy;
            gap_next   = adv_gap;
         end
`endif
         ST_GAP: begin
            if (gap_reg > GAP_W'(1)) begin
               gap_next = gap_reg - GAP_W'(1);
            end else begin
               state_next = ST_SEND;
               idx_next   = IDX_TOP;
               copy_next  = copy_reg + CNT_W'(1);
               gap_next   = '0;
            end
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they land in registers aligned with it.
   always_comb begin
      dout_next   = 1'b0;
      dvalid_next = 1'b0;
      busy_next   = 1'b0;
      done_next   = 1'b0;
      case (state_next)
         ST_SEND: begin
            dout_next   = PATTERN[idx_next];
            dvalid_next = 1'b1;
            busy_next   = 1'b1;
         end
         ST_GAP: begin
            dvalid_next = 1'b1;
            busy_next   = 1'b1;
         end
`ifdef SEQ_TX_PARITY_EN
         ST_PAR: begin
            dout_next   = PAR_BIT;
            dvalid_next = 1'b1;
            busy_next   = 1'b1;
         end
`endif
         ST_DONE: done_next = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg  <= ST_IDLE;
         idx_reg    <= '0;
         copy_reg   <= '0;
         gap_reg    <= '0;
         r_reg      <= '0;
         g_reg      <= '0;
         dout_reg   <= 1'b0;
         dvalid_reg <= 1'b0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         idx_reg    <= idx_next;
         copy_reg   <= copy_next;
         gap_reg    <= gap_next;
         r_reg      <= r_next;
         g_reg      <= g_next;
         dout_reg   <= dout_next;
         dvalid_reg <= dvalid_next;
         busy_reg   <= busy_next;
         done_reg   <= done_next;
      end
   end

   assign dout   = dout_reg;
   assign dvalid = dvalid_reg;
   assign busy   = busy_reg;
   assign done   = done_reg;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: table of transfers checked bit-by-bit against a queued model,
// plus hand sequences for held start, mid-transfer reset and exact bit strings.
module tb_seq_pattern_tx;

`ifdef SEQ_TX_PARITY_EN
   localparam int PAR_EN = 1;
`else
   localparam int PAR_EN = 0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [7:0] repeat_cnt = '0;
   logic [3:0] gap_len = '0;
   logic       dout, dvalid, busy, done;

   int         n_vec = 0;
   int         n_err = 0;
   bit         exp_q[$];
   logic [63:0] got_bits;
   int         got_len;

   typedef struct {
      int r;
      int g;
      bit poke;
      int exp_len;
   } vec_t;
   vec_t vecs[10];

   always #5 clk = ~clk;

   seq_pattern_tx #(
      .PAT_W(4), .PATTERN(4'b1011), .CNT_W(8), .GAP_W(4)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .repeat_cnt(repeat_cnt),
      .gap_len(gap_len), .dout(dout), .dvalid(dvalid), .busy(busy), .done(done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: cycle budget expired", name);
   endtask

   task automatic model_push(input int r, input int g);
      logic [3:0] pat;
      pat = 4'b1011;
      for (int c = 1; c <= r; c++) begin
         for (int b = 3; b >= 0; b--) exp_q.push_back(pat[b]);
         if (PAR_EN != 0) exp_q.push_back(^pat);
         if (c < r) for (int k = 0; k < g; k++) exp_q.push_back(1'b0);
      end
   endtask

   // Entered just after a negedge with the DUT idle; leaves just after a negedge, idle.
   task automatic run_transfer(input int r, input int g, input bit poke, input string tag);
      bit finished;
      bit e;
      finished = 0;
      got_bits = '0;
      got_len  = 0;
      exp_q.delete();
      model_push(r, g);
      start = 1'b1;
      repeat_cnt = 8'(r);
      gap_len = 4'(g);
      @(negedge clk);
      start = 1'b0;
      repeat_cnt = ~8'(r);
      gap_len = ~4'(g);
      for (int cyc = 0; cyc < 6000 && !finished; cyc++) begin
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_dvalid"}, dvalid, 1);
            check({tag, "_busy"}, busy, 1);
            check({tag, "_dout"}, dout, e);
            got_bits = {got_bits[62:0], dout};
            got_len++;
            if (poke) begin
               start = 1'($urandom_range(0, 1));
               repeat_cnt = 8'($urandom_range(0, 255));
               gap_len = 4'($urandom_range(0, 15));
            end
            @(negedge clk);
         end else begin
            check({tag, "_done"}, done, 1);
            check({tag, "_done_busy"}, busy, 0);
            check({tag, "_done_dvalid"}, dvalid, 0);
            finished = 1;
         end
      end
      if (!finished) fail_now({tag, "_timeout"});
      start = 1'b0;
      @(negedge clk);
      check({tag, "_idle_done"}, done, 0);
      check({tag, "_idle_busy"}, busy, 0);
      check({tag, "_idle_dvalid"}, dvalid, 0);
      $display("xfer %s R=%0d G=%0d valid_bits=%0d", tag, r, g, got_len);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      int nvalid;

      vecs[0] = '{3, 2, 1'b0, 16};
      vecs[1] = '{2, 0, 1'b0, 8};
      vecs[2] = '{0, 5, 1'b0, 0};
      vecs[3] = '{1, 0, 1'b0, 4};
      vecs[4] = '{1, 15, 1'b0, 4};
      vecs[5] = '{4, 1, 1'b0, 19};
      vecs[6] = '{5, 3, 1'b0, 32};
      vecs[7] = '{2, 7, 1'b1, 15};
      vecs[8] = '{3, 1, 1'b1, 14};
      vecs[9] = '{255, 15, 1'b0, 4830};

      // Reset held with start asserted: nothing may happen.
      rst = 1'b0;
      start = 1'b1;
      repeat_cnt = 8'd3;
      gap_len = 4'd2;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("rst_dout", dout, 0);
         check("rst_dvalid", dvalid, 0);
         check("rst_busy", busy, 0);
         check("rst_done", done, 0);
      end
      start = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("post_rst_dvalid", dvalid, 0);
      check("post_rst_busy", busy, 0);
      $display("xfer reset done");

      for (int v = 0; v < 10; v++) begin
         run_transfer(vecs[v].r, vecs[v].g, vecs[v].poke, $sformatf("vec%0d", v));
         check($sformatf("vec%0d_len", v), got_len, vecs[v].exp_len + PAR_EN * vecs[v].r);
      end

      // Exact bit strings, with start poked during busy.
`ifdef SEQ_TX_PARITY_EN
      run_transfer(2, 1, 1'b1, "par_basic");
      check("par_basic_bits", got_bits[31:0], 32'b10111010111);
      check("par_basic_len", got_len, 11);
      run_transfer(2, 0, 1'b0, "par_b2b");
      check("par_b2b_bits", got_bits[31:0], 32'b1011110111);
`else
      run_transfer(3, 2, 1'b1, "basic");
      check("basic_bits", got_bits[31:0], 32'b1011001011001011);
      check("basic_len", got_len, 16);
      run_transfer(2, 0, 1'b0, "b2b");
      check("b2b_bits", got_bits[31:0], 32'b10111011);
`endif

      // start held high through DONE restarts only from IDLE.
      start = 1'b1;
      repeat_cnt = 8'd1;
      gap_len = 4'd0;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      check("held_done_seen", seen, 1);
      @(negedge clk);
      check("held_idle_dvalid", dvalid, 0);
      check("held_idle_done", done, 0);
      @(negedge clk);
      check("held_restart_dvalid", dvalid, 1);
      check("held_restart_dout", dout, 1);
      start = 1'b0;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      check("held_drain_done", seen, 1);
      @(negedge clk);
      $display("xfer held_start done");

      // Reset in the middle of the second copy.
      start = 1'b1;
      repeat_cnt = 8'd4;
      gap_len = 4'd1;
      @(negedge clk);
      start = 1'b0;
      nvalid = 0;
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (dvalid) nvalid++;
         if (nvalid == 7 + PAR_EN) seen = 1;
         else @(negedge clk);
      end
      check("midrst_reached", seen, 1);
      rst = 1'b0;
      @(negedge clk);
      check("midrst_dout", dout, 0);
      check("midrst_dvalid", dvalid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("midrst_quiet_done", done, 0);
         check("midrst_quiet_dvalid", dvalid, 0);
      end
      $display("xfer mid_reset done");
      run_transfer(1, 0, 1'b0, "after_rst");
      check("after_rst_bits", got_bits[31:0], (PAR_EN != 0) ? 32'b10111 : 32'b1011);
      check("after_rst_len", got_len, 4 + PAR_EN);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
